tft_bus_arbiter: RTL and testbench

Shares the single `tft_spi` byte transmitter between several TFT drawing engines: the initializer, the scene exhibitor, the player sprite and any overlay engine. Each engine requests the bus, receives an exclusive grant, streams bytes through the arbiter and releases the bus. The arbiter selects the owner by fixed priority or round-robin, drains the last byte before handing over, and revokes ownership from a requester that stalls. It replaces the ad-hoc priority mux in the top level that drives the transmitter.

---
 rtl/tft_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_tft_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_bus_arbiter.sv
// tft_bus_arbiter
// Shares one tft_spi byte transmitter between NUM_REQ drawing engines.
// Each engine requests the bus, receives a one-hot registered grant, and
// streams bytes through the arbiter. The owner is chosen by fixed priority
// (index 0 highest) or by round-robin. A released bus is drained (waits for
// spi_busy low) before handover. An owner that stays idle for TIMEOUT
// cycles is revoked.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req               per-requester bus request, held for the whole tenure
//   req_data          per-requester byte, requester i on [8i+7:8i]
//   req_dc            per-requester data/command flag
//   req_transmit      per-requester one-cycle send strobe
//   grant             one-hot grant (registered)
//   req_busy          spi_busy for the owner, 1 for everyone else
//   spi_data/dc/transmit  forwarded owner signals to the transmitter
//   spi_busy          transmitter busy
//   owner             index of the current or last owner
//   bus_idle          high while the arbiter is in IDLE
//   byte_count        strobes forwarded this tenure, saturating
//   timeout_err       one-cycle pulse on forced revoke
module tft_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_dc,
  input  logic [NUM_REQ-1:0]         req_transmit,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         req_busy,
  output logic [7:0]                 spi_data,
  output logic                       spi_dc,
  output logic                       spi_transmit,
  input  logic                       spi_busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       bus_idle,
  output logic [15:0]                byte_count,
  output logic                       timeout_err
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int SW = OW + 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [NUM_REQ-1:0] GRANT_LSB = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [15:0]         byte_count_q, byte_count_d;
  logic [CW-1:0]       idle_cnt_q, idle_cnt_d;
  logic                timeout_err_q, timeout_err_d;

  logic [OW-1:0]       win_s;
  logic                win_vld_s;
  logic [SW-1:0]       scan_sum_s;
  logic [OW-1:0]       scan_idx_s;

  // Winner search: scan NUM_REQ slots starting at 0 (fixed) or at the
  // round-robin pointer, wrapping modulo NUM_REQ; first set request wins.
  always_comb begin
    win_s      = '0;
    win_vld_s  = 1'b0;
    scan_sum_s = '0;
    scan_idx_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum_s = (RR_MODE != 0) ? ({1'b0, rr_ptr_q} + SW'(k)) : SW'(k);
      if (scan_sum_s >= SW'(NUM_REQ)) begin
        scan_sum_s = scan_sum_s - SW'(NUM_REQ);
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[OW-1:0];
      if (!win_vld_s && req[scan_idx_s]) begin
        win_vld_s = 1'b1;
        win_s     = scan_idx_s;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // Zero-latency forwarding of the owner's byte/strobe and busy fan-out.
  always_comb begin
    spi_data     = 8'h00;
    spi_dc       = 1'b0;
    spi_transmit = 1'b0;
    req_busy     = '1;
    if (state_q == ST_OWNED) begin
      spi_data          = 8'(req_data >> {owner_q, 3'b000});
      spi_dc            = req_dc[owner_q];
      spi_transmit      = req_transmit[owner_q];
      req_busy[owner_q] = spi_busy;
    end else begin
      req_busy = '1;
    end
  end

  // Next-state logic for the arbitration FSM and its counters.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    byte_count_d  = byte_count_q;
    idle_cnt_d    = '0;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld_s) begin
          state_d      = ST_OWNED;
          grant_d      = GRANT_LSB << win_s;
          owner_d      = win_s;
          rr_ptr_d     = (win_s == OW'(NUM_REQ - 1)) ? '0 : (win_s + OW'(1));
          byte_count_d = 16'h0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWNED: begin
        if (spi_transmit && (byte_count_q != 16'hFFFF)) begin
          byte_count_d = byte_count_q + 16'd1;
        end else begin
          byte_count_d = byte_count_q;
        end
        // A release wins over a simultaneous timeout: no revoke is reported.
        if (!req[owner_q]) begin
          state_d = ST_DRAIN;
          grant_d = '0;
        end else if (spi_transmit || spi_busy) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
          state_d       = ST_DRAIN;
          grant_d       = '0;
          timeout_err_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (!spi_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      byte_count_q  <= 16'h0000;
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      byte_count_q  <= byte_count_d;
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign byte_count  = byte_count_q;
  assign timeout_err = timeout_err_q;
  assign bus_idle    = (state_q == ST_IDLE);

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Bench for tft_bus_arbiter: one fixed-priority and one round-robin
// instance (both TIMEOUT=8), directed scenarios plus random traffic, all
// compared every cycle against a tenure-level reference model.
module tb_tft_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_s  [2];
  logic [31:0] data_s [2];
  logic [3:0]  dc_s   [2];
  logic [3:0]  tx_s   [2];
  logic        busy_s [2];

  logic [3:0]  grant_w    [2];
  logic [3:0]  req_busy_w [2];
  logic [7:0]  spi_data_w [2];
  logic        spi_dc_w   [2];
  logic        spi_tx_w   [2];
  logic [1:0]  owner_w    [2];
  logic        bus_idle_w [2];
  logic [15:0] bc_w       [2];
  logic        terr_w     [2];

  tft_bus_arbiter #(.NUM_REQ(N), .RR_MODE(0), .TIMEOUT(TO)) u_fix (
    .clk(clk), .rst(rst), .req(req_s[0]), .req_data(data_s[0]),
    .req_dc(dc_s[0]), .req_transmit(tx_s[0]), .grant(grant_w[0]),
    .req_busy(req_busy_w[0]), .spi_data(spi_data_w[0]), .spi_dc(spi_dc_w[0]),
    .spi_transmit(spi_tx_w[0]), .spi_busy(busy_s[0]), .owner(owner_w[0]),
    .bus_idle(bus_idle_w[0]), .byte_count(bc_w[0]), .timeout_err(terr_w[0])
  );

  tft_bus_arbiter #(.NUM_REQ(N), .RR_MODE(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst), .req(req_s[1]), .req_data(data_s[1]),
    .req_dc(dc_s[1]), .req_transmit(tx_s[1]), .grant(grant_w[1]),
    .req_busy(req_busy_w[1]), .spi_data(spi_data_w[1]), .spi_dc(spi_dc_w[1]),
    .spi_transmit(spi_tx_w[1]), .spi_busy(busy_s[1]), .owner(owner_w[1]),
    .bus_idle(bus_idle_w[1]), .byte_count(bc_w[1]), .timeout_err(terr_w[1])
  );

  int n_checks;
  int n_fail;
  int cyc;

  // Reference model: phase 0 = free, 1 = someone holds the bus, 2 = waiting
  // for the transmitter to finish.
  int m_ph   [2];
  int m_own  [2];
  int m_ptr  [2];
  int m_bc   [2];
  int m_idle [2];
  int m_terr [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic string tg(input int d, input string n);
    return $sformatf("%s_%s", (d == 0) ? "fix" : "rr", n);
  endfunction

  function automatic int pick(input int d);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (d == 1) ? ((m_ptr[d] + k) % N) : k;
      if (req_s[d][i]) return i;
    end
    return -1;
  endfunction

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [3:0]  eb;
      logic [31:0] ed;
      bit          own_now;
      own_now = (m_ph[d] == 1);
      for (int i = 0; i < N; i++) eb[i] = (own_now && m_own[d] == i) ? busy_s[d] : 1'b1;
      ed = own_now ? ((data_s[d] >> (8 * m_own[d])) & 32'hFF) : 32'h0;
      check_eq(tg(d, "grant"), grant_w[d], own_now ? (32'h1 << m_own[d]) : 32'h0);
      check_eq(tg(d, "owner"), owner_w[d], m_own[d]);
      check_eq(tg(d, "bus_idle"), bus_idle_w[d], m_ph[d] == 0);
      check_eq(tg(d, "byte_count"), bc_w[d], m_bc[d]);
      check_eq(tg(d, "timeout_err"), terr_w[d], m_terr[d]);
      check_eq(tg(d, "spi_data"), spi_data_w[d], ed);
      check_eq(tg(d, "spi_dc"), spi_dc_w[d], own_now ? dc_s[d][m_own[d]] : 1'b0);
      check_eq(tg(d, "spi_transmit"), spi_tx_w[d], own_now ? tx_s[d][m_own[d]] : 1'b0);
      check_eq(tg(d, "req_busy"), req_busy_w[d], eb);
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_ph[d] = 0; m_own[d] = 0; m_ptr[d] = 0;
        m_bc[d] = 0; m_idle[d] = 0; m_terr[d] = 0;
      end else if (m_ph[d] == 0) begin
        int w;
        m_terr[d] = 0;
        w = pick(d);
        if (w >= 0) begin
          m_ph[d] = 1; m_own[d] = w; m_ptr[d] = (w + 1) % N;
          m_bc[d] = 0; m_idle[d] = 0;
        end
      end else if (m_ph[d] == 1) begin
        m_terr[d] = 0;
        if (tx_s[d][m_own[d]] && m_bc[d] < 65535) m_bc[d]++;
        if (!req_s[d][m_own[d]]) begin
          m_ph[d] = 2;
        end else if (tx_s[d][m_own[d]] || busy_s[d]) begin
          m_idle[d] = 0;
        end else begin
          m_idle[d]++;
          if (m_idle[d] == TO) begin
            m_terr[d] = 1;
            m_ph[d]   = 2;
          end
        end
      end else begin
        m_terr[d] = 0;
        if (!busy_s[d]) m_ph[d] = 0;
      end
    end
  endtask

  // One cycle: compare against the model, advance the model, clock the DUTs.
  task automatic step();
    #1;
    check_all();
    model_update();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_s[d] = 4'h0; data_s[d] = 32'h0; dc_s[d] = 4'h0; tx_s[d] = 4'h0; busy_s[d] = 1'b0;
      m_ph[d] = 0; m_own[d] = 0; m_ptr[d] = 0; m_bc[d] = 0; m_idle[d] = 0; m_terr[d] = 0;
    end
    @(negedge clk);
    step(); step();
    check_eq("reset_grant", grant_w[0], 4'h0);
    check_eq("reset_bus_idle", bus_idle_w[0], 1'b1);
    rst = 1'b0;

    // Fixed priority: lowest index wins, handover gap of two cycles.
    req_s[0] = 4'b0110;
    step();
    check_eq("fix_first_grant", grant_w[0], 4'b0010);
    step(); step();
    req_s[0] = 4'b0100;
    step();
    check_eq("fix_gap1", grant_w[0], 4'b0000);
    step();
    check_eq("fix_gap2", grant_w[0], 4'b0000);
    step();
    check_eq("fix_second_grant", grant_w[0], 4'b0100);
    req_s[0] = 4'b0000;
    step(); step();

    // Forwarding from owner 2 while requester 0 strobes concurrently.
    req_s[0] = 4'b0100;
    step();
    req_s[0] = 4'b0101;
    data_s[0] = {8'h00, 8'h2A, 8'h00, 8'hFF}; dc_s[0] = 4'b0001; tx_s[0] = 4'b0101;
    #1;
    check_eq("fwd_data_2a", spi_data_w[0], 8'h2A);
    check_eq("fwd_dc_0", spi_dc_w[0], 1'b0);
    check_eq("fwd_req_busy0", req_busy_w[0][0], 1'b1);
    step();
    data_s[0] = {8'h00, 8'h55, 8'h00, 8'hFF}; dc_s[0] = 4'b0100; tx_s[0] = 4'b0101;
    #1;
    check_eq("fwd_data_55", spi_data_w[0], 8'h55);
    check_eq("fwd_dc_1", spi_dc_w[0], 1'b1);
    step();
    tx_s[0] = 4'b0001;
    #1;
    check_eq("fwd_nonowner_strobe", spi_tx_w[0], 1'b0);
    check_eq("fwd_count", bc_w[0], 16'd2);
    step();
    tx_s[0] = 4'b0000; req_s[0] = 4'b0001;
    step(); step(); step();
    check_eq("fwd_waiter_granted", grant_w[0], 4'b0001);
    req_s[0] = 4'b0000;
    step(); step();

    // Drain held by spi_busy; next grant two cycles after busy falls.
    req_s[0] = 4'b0001;
    step();
    busy_s[0] = 1'b1; req_s[0] = 4'b0010;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("drain_hold_idle", bus_idle_w[0], 1'b0);
      check_eq("drain_hold_grant", grant_w[0], 4'b0000);
    end
    busy_s[0] = 1'b0;
    step();
    check_eq("drain_gap_grant", grant_w[0], 4'b0000);
    check_eq("drain_to_idle", bus_idle_w[0], 1'b1);
    step();
    check_eq("drain_next_grant", grant_w[0], 4'b0010);
    req_s[0] = 4'b0000;
    step(); step();

    // Timeout: owner 1 stays silent.
    req_s[0] = 4'b0010;
    step();
    check_eq("to_grant", grant_w[0], 4'b0010);
    for (int i = 1; i < 8; i++) begin
      step();
      check_eq("to_early", terr_w[0], 1'b0);
      check_eq("to_held", grant_w[0], 4'b0010);
    end
    step();
    check_eq("to_pulse", terr_w[0], 1'b1);
    check_eq("to_revoked", grant_w[0], 4'b0000);
    step();
    check_eq("to_pulse_end", terr_w[0], 1'b0);
    step();
    check_eq("to_regrant", grant_w[0], 4'b0010);
    req_s[0] = 4'b0000;
    step(); step();

    // Round-robin: all requesting, three strobes per tenure.
    req_s[1] = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      int o;
      o = t % N;
      for (int n = 0; n < 6 && grant_w[1] == 4'h0; n++) step();
      check_eq("rr_grant_seen", grant_w[1] != 4'h0, 1'b1);
      check_eq("rr_owner", owner_w[1], o);
      for (int s = 0; s < 3; s++) begin
        tx_s[1] = 4'b0001 << o;
        step();
      end
      tx_s[1] = 4'b0000;
      req_s[1][o] = 1'b0;
      step();
      check_eq("rr_release_count", bc_w[1], 16'd3);
      req_s[1] = 4'b1111;
    end
    req_s[1] = 4'b0000;
    step(); step(); step();

    // Reset in the middle of a tenure with a strobe active.
    req_s[0] = 4'b0001;
    step();
    tx_s[0] = 4'b0001;
    step(); step();
    rst = 1'b1;
    step();
    check_eq("rst_grant", grant_w[0], 4'b0000);
    check_eq("rst_transmit", spi_tx_w[0], 1'b0);
    check_eq("rst_byte_count", bc_w[0], 16'd0);
    check_eq("rst_bus_idle", bus_idle_w[0], 1'b1);
    rst = 1'b0; tx_s[0] = 4'b0000; req_s[0] = 4'b0000;
    step();

    // Random traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 7) == 0) req_s[d][i] = ~req_s[d][i];
          tx_s[d][i] = ($urandom_range(0, 4) == 0);
        end
        data_s[d] = $urandom;
        dc_s[d]   = 4'($urandom);
        busy_s[d] = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
